// File: rtl/imem_pkg.sv
// Shared types and address helpers for the instruction-memory port arbiter.
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Helpers take a wide, zero-extended byte address so any ADDR_W up to 64 can share them.
  localparam int unsigned FN_ADDR_W = 64;

  function automatic logic [FN_ADDR_W-1:0] word_idx(input logic [FN_ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_ok(input logic [FN_ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < FN_ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port instruction memory: asynchronous read, synchronous write, no reset.
module imem_sp_ram #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory port between core fetch and a program loader:
// loader owns the port during BOOT, fetch has priority in RUN with a bounded loader wait.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_last,
  output logic              boot_done,
  output logic              ld_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e      state_q;
  logic        boot_done_q;
  logic        ld_err_q;
  logic [15:0] words_q;
  logic [7:0]  starve_q;

  logic             grant_ld;
  logic             fetch_gnt;
  logic             xfer;
  logic             wr_ok;
  logic             we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_rdata;

  always_comb begin
    grant_ld    = 1'b0;
    ld_ready    = 1'b0;
    fetch_stall = 1'b1;
    fetch_gnt   = 1'b0;
    if (state_q == ST_BOOT) begin
      grant_ld    = ld_valid;
      ld_ready    = 1'b1;
      fetch_stall = 1'b1;
    end else begin
      grant_ld    = ld_valid && (!fetch_req || (starve_q == 8'(STARVE_LIM)));
      ld_ready    = grant_ld;
      fetch_stall = fetch_req && grant_ld;
      fetch_gnt   = fetch_req && !grant_ld;
    end
  end

  assign xfer  = ld_valid && ld_ready;
  assign wr_ok = addr_ok(FN_ADDR_W'(ld_addr), DEPTH);
  assign we    = xfer && wr_ok;

  // One port op per cycle: an accepted loader word (even a dropped one) takes the port from fetch.
  assign ram_addr = xfer ? IDX_W'(word_idx(FN_ADDR_W'(ld_addr)))
                         : IDX_W'(word_idx(FN_ADDR_W'(fetch_addr)));

  imem_sp_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .addr_i (ram_addr),
    .wdata_i(ld_wdata),
    .rdata_o(ram_rdata)
  );

  assign fetch_rdata = fetch_gnt ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      boot_done_q <= 1'b0;
      ld_err_q    <= 1'b0;
      words_q     <= '0;
      starve_q    <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          starve_q <= '0;
          if (xfer && ld_last) begin
            state_q     <= ST_RUN;
            boot_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!ld_valid || grant_ld) starve_q <= '0;
          else if (fetch_req)        starve_q <= starve_q + 8'd1;
        end
        default: state_q <= ST_BOOT;
      endcase
      if (xfer && !wr_ok)       ld_err_q <= 1'b1;
      if (we && words_q != '1)  words_q  <= words_q + 16'd1;
    end
  end

  assign boot_done    = boot_done_q;
  assign ld_err       = ld_err_q;
  assign words_loaded = words_q;

endmodule
